// File: rtl/tmds_channel_decoder.sv
// TMDS channel decoder: word alignment search/lock, control-token and 8b data decode.
// Optional TERC4 symbol matching while locked is enabled with `define TMDS_DEC_TERC4_EN.
module tmds_channel_decoder #(
    parameter int LOCK_COUNT     = 16,
    parameter int SEARCH_TIMEOUT = 1024
) (
    input  logic       pixclk,
    input  logic       rst,
    input  logic [9:0] sym_in,
    input  logic       sym_valid,
    output logic [7:0] data_out,
    output logic [1:0] c_out,
    output logic       de_out,
    output logic       valid_out,
    output logic       locked,
    output logic [3:0] slip,
    output logic       lock_lost,
    output logic [3:0] terc4_out,
    output logic       terc4_hit
);
    localparam int RUN_W = $clog2(LOCK_COUNT + 1);
    localparam int GAP_W = $clog2(SEARCH_TIMEOUT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_COUNT);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(SEARCH_TIMEOUT);

    typedef enum logic {ST_SEARCH, ST_LOCKED} state_t;

    state_t           state_q, state_d;
    logic [9:0]       prev_q, prev_d;
    logic             have_prev_q, have_prev_d;
    logic [3:0]       slip_q, slip_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [7:0]       data_q, data_d;
    logic [1:0]       c_q, c_d;
    logic             de_q, de_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             lost_q, lost_d;

    logic [19:0]      hist;
    logic [9:0]       word;
    logic             is_token;
    logic [1:0]       token_c;
    logic [7:0]       d_bits;
    logic [7:0]       dec_byte;
    logic [RUN_W-1:0] run_inc;
    logic [GAP_W-1:0] gap_inc;
    logic [3:0]       slip_next;
    logic             eval;

    assign hist      = {sym_in, prev_q};
    assign word      = 10'(hist >> slip_q);
    assign run_inc   = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
    assign gap_inc   = (gap_q == GAP_MAX) ? gap_q : gap_q + 1'b1;
    assign slip_next = (slip_q == 4'd9) ? 4'd0 : slip_q + 4'd1;
    assign eval      = sym_valid & have_prev_q;

    always_comb begin
        is_token = 1'b1;
        token_c  = 2'b00;
        case (word)
            10'h354: token_c = 2'b00;
            10'h0AB: token_c = 2'b01;
            10'h154: token_c = 2'b10;
            10'h2AB: token_c = 2'b11;
            default: is_token = 1'b0;
        endcase
    end

    always_comb begin
        d_bits      = word[7:0] ^ {8{word[9]}};
        dec_byte    = 8'h00;
        dec_byte[0] = d_bits[0];
        for (int i = 1; i < 8; i++) begin
            dec_byte[i] = word[8] ? (d_bits[i] ^ d_bits[i-1]) : ~(d_bits[i] ^ d_bits[i-1]);
        end
    end

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        slip_d      = slip_q;
        run_d       = run_q;
        gap_d       = gap_q;
        data_d      = data_q;
        c_d         = c_q;
        de_d        = de_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        lost_d      = 1'b0;

        if (sym_valid) begin
            prev_d      = sym_in;
            have_prev_d = 1'b1;
        end

        // The very first accepted word only primes the history; nothing is decoded from it.
        if (eval) begin
            valid_d = 1'b1;
            if (is_token) begin
                de_d = 1'b0;
                c_d  = token_c;
            end else begin
                de_d   = 1'b1;
                data_d = dec_byte;
            end

            case (state_q)
                ST_SEARCH: begin
                    if (is_token) begin
                        gap_d = '0;
                        run_d = run_inc;
                        if (run_inc == RUN_MAX) begin
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                            run_d    = '0;
                        end
                    end else begin
                        run_d = '0;
                        gap_d = gap_inc;
                        if (gap_inc == GAP_MAX) begin
                            slip_d = slip_next;
                            gap_d  = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (is_token) begin
                        gap_d = '0;
                    end else begin
                        gap_d = gap_inc;
                        if (gap_inc == GAP_MAX) begin
                            state_d  = ST_SEARCH;
                            locked_d = 1'b0;
                            lost_d   = 1'b1;
                            slip_d   = slip_next;
                            gap_d    = '0;
                            run_d    = '0;
                        end
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end
    end

    always_ff @(posedge pixclk) begin
        if (rst) begin
            state_q     <= ST_SEARCH;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            slip_q      <= '0;
            run_q       <= '0;
            gap_q       <= '0;
            data_q      <= '0;
            c_q         <= '0;
            de_q        <= 1'b0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            slip_q      <= slip_d;
            run_q       <= run_d;
            gap_q       <= gap_d;
            data_q      <= data_d;
            c_q         <= c_d;
            de_q        <= de_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            lost_q      <= lost_d;
        end
    end

    assign data_out  = data_q;
    assign c_out     = c_q;
    assign de_out    = de_q;
    assign valid_out = valid_q;
    assign locked    = locked_q;
    assign slip      = slip_q;
    assign lock_lost = lost_q;

`ifdef TMDS_DEC_TERC4_EN
    logic [3:0] terc4_q, terc4_d;
    logic       terc4_hit_q, terc4_hit_d;
    logic [4:0] terc4_m;

    always_comb begin
        case (word)
            10'h29C: terc4_m = {1'b1, 4'd0};
            10'h263: terc4_m = {1'b1, 4'd1};
            10'h2E4: terc4_m = {1'b1, 4'd2};
            10'h2E2: terc4_m = {1'b1, 4'd3};
            10'h171: terc4_m = {1'b1, 4'd4};
            10'h11E: terc4_m = {1'b1, 4'd5};
            10'h18E: terc4_m = {1'b1, 4'd6};
            10'h13C: terc4_m = {1'b1, 4'd7};
            10'h2CC: terc4_m = {1'b1, 4'd8};
            10'h139: terc4_m = {1'b1, 4'd9};
            10'h19C: terc4_m = {1'b1, 4'd10};
            10'h2C6: terc4_m = {1'b1, 4'd11};
            10'h28E: terc4_m = {1'b1, 4'd12};
            10'h271: terc4_m = {1'b1, 4'd13};
            10'h163: terc4_m = {1'b1, 4'd14};
            10'h2C3: terc4_m = {1'b1, 4'd15};
            default: terc4_m = 5'd0;
        endcase
    end

    always_comb begin
        terc4_d     = terc4_q;
        terc4_hit_d = terc4_hit_q;
        if (eval) begin
            terc4_hit_d = (state_q == ST_LOCKED) & terc4_m[4];
            terc4_d     = (state_q == ST_LOCKED) ? terc4_m[3:0] : 4'd0;
        end
    end

    always_ff @(posedge pixclk) begin
        if (rst) begin
            terc4_q     <= '0;
            terc4_hit_q <= 1'b0;
        end else begin
            terc4_q     <= terc4_d;
            terc4_hit_q <= terc4_hit_d;
        end
    end

    assign terc4_out = terc4_q;
    assign terc4_hit = terc4_hit_q;
`else
    assign terc4_out = 4'd0;
    assign terc4_hit = 1'b0;
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: lock, decode, slip search, lock loss, reset.
// Output for a word appears one sym_valid later, since alignment at slip 0 selects the previous word.
module tb_tmds_channel_decoder;
    logic       pixclk = 1'b0;
    logic       rst;
    logic [9:0] sym_in;
    logic       sym_valid;
    logic [7:0] data_out;
    logic [1:0] c_out;
    logic       de_out;
    logic       valid_out;
    logic       locked;
    logic [3:0] slip;
    logic       lock_lost;
    logic [3:0] terc4_out;
    logic       terc4_hit;

    int n_total  = 0;
    int n_passed = 0;

    // 0x354 token seen through a 3-bit rotated word boundary
    localparam logic [9:0] ROT_TOK = 10'h2A6;

    tmds_channel_decoder dut (
        .pixclk    (pixclk),
        .rst       (rst),
        .sym_in    (sym_in),
        .sym_valid (sym_valid),
        .data_out  (data_out),
        .c_out     (c_out),
        .de_out    (de_out),
        .valid_out (valid_out),
        .locked    (locked),
        .slip      (slip),
        .lock_lost (lock_lost),
        .terc4_out (terc4_out),
        .terc4_hit (terc4_hit)
    );

    always #5 pixclk = ~pixclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic send(input logic [9:0] w);
        @(negedge pixclk);
        sym_in    = w;
        sym_valid = 1'b1;
        @(posedge pixclk);
        #1;
        sym_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge pixclk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge pixclk);
        rst = 1'b1;
        @(posedge pixclk);
        #1;
        chk("rst_data",   32'(data_out),  32'h0);
        chk("rst_c",      32'(c_out),     32'h0);
        chk("rst_de",     32'(de_out),    32'h0);
        chk("rst_valid",  32'(valid_out), 32'h0);
        chk("rst_locked", 32'(locked),    32'h0);
        chk("rst_slip",   32'(slip),      32'h0);
        chk("rst_lost",   32'(lock_lost), 32'h0);
        chk("rst_t4out",  32'(terc4_out), 32'h0);
        chk("rst_t4hit",  32'(terc4_hit), 32'h0);
        @(negedge pixclk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        sym_in    = 10'h000;
        sym_valid = 1'b0;
        repeat (2) @(posedge pixclk);
        #1;
        pulse_reset();

        // Lock at slip 0: 16 evaluated tokens need 17 accepted words
        repeat (16) send(10'h354);
        chk("lock_early", 32'(locked), 32'h0);
        send(10'h354);
        chk("lock_at_17",   32'(locked),    32'h1);
        chk("lock_c",       32'(c_out),     32'h0);
        chk("lock_de",      32'(de_out),    32'h0);
        chk("lock_valid",   32'(valid_out), 32'h1);
        idle();
        chk("valid_idle",   32'(valid_out), 32'h0);
        chk("locked_hold",  32'(locked),    32'h1);

        // Data decode and control tokens
        send(10'h100);
        send(10'h1FF);
        chk("dec_100",    32'(data_out), 32'h00);
        chk("dec_100_de", 32'(de_out),   32'h1);
        send(10'h0FF);
        chk("dec_1FF",    32'(data_out), 32'h01);
        chk("dec_1FF_de", 32'(de_out),   32'h1);
        send(10'h354);
        chk("dec_0FF",    32'(data_out), 32'hFF);
        send(10'h29C);
        chk("tok_de",        32'(de_out),   32'h0);
        chk("tok_data_hold", 32'(data_out), 32'hFF);
        send(10'h354);
        chk("dec_29C",    32'(data_out), 32'h5B);
        chk("dec_29C_de", 32'(de_out),   32'h1);
`ifdef TMDS_DEC_TERC4_EN
        chk("t4_hit",  32'(terc4_hit), 32'h1);
`else
        chk("t4_hit",  32'(terc4_hit), 32'h0);
`endif
        chk("t4_out",  32'(terc4_out), 32'h0);
        send(10'h0AB);
        chk("c_354",   32'(c_out),     32'h0);
        chk("t4_clr",  32'(terc4_hit), 32'h0);
        send(10'h154);
        chk("c_0AB",   32'(c_out),     32'h1);
        send(10'h2AB);
        chk("c_154",   32'(c_out),     32'h2);
        send(10'h2AB);
        chk("c_2AB",      32'(c_out),    32'h3);
        chk("c_data_hold",32'(data_out), 32'h5B);
        chk("still_lock", 32'(locked),   32'h1);

        pulse_reset();

        // Rotated token stream: slip walks 1,2,3 then locks
        repeat (1024) send(ROT_TOK);
        chk("slip0_edge", 32'(slip), 32'h0);
        send(ROT_TOK);
        chk("slip1", 32'(slip), 32'h1);
        repeat (1023) send(ROT_TOK);
        chk("slip1_edge", 32'(slip), 32'h1);
        send(ROT_TOK);
        chk("slip2", 32'(slip), 32'h2);
        repeat (1024) send(ROT_TOK);
        chk("slip3", 32'(slip), 32'h3);
        repeat (15) send(ROT_TOK);
        chk("rot_lock_early", 32'(locked), 32'h0);
        send(ROT_TOK);
        chk("rot_lock", 32'(locked), 32'h1);
        chk("rot_c",    32'(c_out),  32'h0);
        chk("rot_de",   32'(de_out), 32'h0);

        // Loss of lock after 1024 data words
        repeat (1023) send(10'h100);
        chk("lost_early_lock", 32'(locked),    32'h1);
        chk("lost_early_pulse",32'(lock_lost), 32'h0);
        send(10'h100);
        chk("lost_pulse",  32'(lock_lost), 32'h1);
        chk("lost_locked", 32'(locked),    32'h0);
        chk("lost_slip",   32'(slip),      32'h4);
        idle();
        chk("lost_one_cycle", 32'(lock_lost), 32'h0);

        // Keep searching through the 9 -> 0 wrap back to slip 3
        for (int k = 1; k <= 9; k++) begin
            repeat (1024) send(10'h100);
            chk("slip_walk", 32'(slip), 32'((4 + k) % 10));
        end

        // Relock at slip 3 (first word straddles the stream change), then reset mid-lock
        repeat (16) send(ROT_TOK);
        chk("relock_early", 32'(locked), 32'h0);
        send(ROT_TOK);
        chk("relock",      32'(locked), 32'h1);
        chk("relock_slip", 32'(slip),   32'h3);
        pulse_reset();
        send(10'h354);
        chk("post_rst_first_valid", 32'(valid_out), 32'h0);
        send(10'h354);
        chk("post_rst_second_valid", 32'(valid_out), 32'h1);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end
endmodule
